// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Control unit for the 16-bit multi-cycle processor: sequences fetch, decode,
// execute, memory access and writeback, and drives every datapath select and
// strobe. Memory states stall on input_mem_ready.
// Optional feature: define ILLEGAL_TRAP_EN to send opcodes B-F to a TRAP state
// that raises output_illegal until reset; otherwise they decode as a NOP.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] input_opcode,
    input  logic       input_Zero,
    input  logic       input_negative,
    input  logic       input_mem_ready,
    output logic [1:0] output_ALUSrcA,
    output logic [1:0] output_ALUSrcB,
    output logic [2:0] output_ALUOp,
    output logic       output_PCSrc,
    output logic       output_PCWrite,
    output logic       output_IRWrite,
    output logic       output_IorD,
    output logic       output_MemRead,
    output logic       output_MemWrite,
    output logic       output_RegWrite,
    output logic       output_MemtoReg,
    output logic       output_RegDst,
    output logic [3:0] output_state,
    output logic       output_illegal
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic [3:0] OP_BEQ = 4'h7;
    localparam logic [3:0] OP_BNE = 4'h8;
    localparam logic [3:0] OP_BLT = 4'h9;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_RWB      = 4'd7,
        S_EXEC_I   = 4'd8,
        S_IWB      = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    state_t     r_state;
    logic [3:0] r_opcode;
    logic       w_taken;

    // State sequencing; the opcode is captured in DECODE so later IR changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            // NOTE: r_opcode is only read after DECODE rewrites it, but resetting it keeps the branch decode X-free.
            r_opcode <= 4'h0;
        end else begin
            // NOTE: non-blocking assignments so every state register updates from pre-edge values.
            case (r_state)
                S_FETCH:    if (input_mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_opcode <= input_opcode;
                    case (input_opcode)
                        4'h0, 4'h1, 4'h2, 4'h3: r_state <= S_EXEC_R;
                        4'h4:                   r_state <= S_EXEC_I;
                        4'h5, 4'h6:             r_state <= S_MEMADDR;
                        4'h7, 4'h8, 4'h9:       r_state <= S_BRANCH;
                        4'hA:                   r_state <= S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                        default:                r_state <= S_TRAP;
`else
                        default:                r_state <= S_FETCH;
`endif
                    endcase
                end
                S_EXEC_R:   r_state <= S_RWB;
                S_RWB:      r_state <= S_FETCH;
                S_EXEC_I:   r_state <= S_IWB;
                S_IWB:      r_state <= S_FETCH;
                S_MEMADDR:  r_state <= (r_opcode == 4'h5) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (input_mem_ready) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (input_mem_ready) r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                S_JUMP:     r_state <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
                S_TRAP:     r_state <= S_TRAP;
`else
                S_TRAP:     r_state <= S_FETCH;
`endif
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Branch condition evaluated from the latched opcode and live ALU flags
    always_comb begin
        case (r_opcode)
            OP_BEQ:  w_taken = input_Zero;
            OP_BNE:  w_taken = !input_Zero;
            OP_BLT:  w_taken = input_negative;
            default: w_taken = 1'b0;
        endcase
    end

    // Output decode from the state register; everything held at 0 while in reset
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        output_ALUSrcA  = 2'd0;
        output_ALUSrcB  = 2'd0;
        output_ALUOp    = ALU_ADD;
        output_PCSrc    = 1'b0;
        output_PCWrite  = 1'b0;
        output_IRWrite  = 1'b0;
        output_IorD     = 1'b0;
        output_MemRead  = 1'b0;
        output_MemWrite = 1'b0;
        output_RegWrite = 1'b0;
        output_MemtoReg = 1'b0;
        output_RegDst   = 1'b0;
        output_illegal  = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    output_MemRead = 1'b1;
                    output_ALUSrcB = 2'd1;
                    output_IRWrite = input_mem_ready;
                    output_PCWrite = input_mem_ready;
                end
                S_DECODE:   output_ALUSrcB = 2'd2;
                S_EXEC_R: begin
                    output_ALUSrcA = 2'd2;
                    case (r_opcode[1:0])
                        2'd0:    output_ALUOp = ALU_ADD;
                        2'd1:    output_ALUOp = ALU_SUB;
                        2'd2:    output_ALUOp = ALU_AND;
                        default: output_ALUOp = ALU_OR;
                    endcase
                end
                S_RWB: begin
                    output_RegWrite = 1'b1;
                    output_RegDst   = 1'b1;
                end
                S_EXEC_I, S_MEMADDR: begin
                    output_ALUSrcA = 2'd2;
                    output_ALUSrcB = 2'd2;
                end
                S_IWB:      output_RegWrite = 1'b1;
                S_MEMREAD: begin
                    output_MemRead = 1'b1;
                    output_IorD    = 1'b1;
                end
                S_MEMWB: begin
                    output_RegWrite = 1'b1;
                    output_MemtoReg = 1'b1;
                end
                S_MEMWRITE: begin
                    output_MemWrite = 1'b1;
                    output_IorD     = 1'b1;
                end
                S_BRANCH: begin
                    output_ALUSrcA = 2'd2;
                    output_ALUOp   = ALU_SUB;
                    output_PCSrc   = 1'b1;
                    output_PCWrite = w_taken;
                end
                S_JUMP: begin
                    output_PCSrc   = 1'b1;
                    output_PCWrite = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP:     output_illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign output_state = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: the driver pushes the
// hand-derived expected output word for every cycle it drives, and a monitor
// on the falling edge pops and compares against the DUT.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       zero = 1'b0;
    logic       neg = 1'b0;
    logic       rdy = 1'b1;

    logic [1:0] src_a, src_b;
    logic [2:0] alu_op;
    logic       pc_src, pc_write, ir_write, iord, mem_read, mem_write;
    logic       reg_write, mem_to_reg, reg_dst, illegal;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [20:0] word;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .input_opcode    (opcode),
        .input_Zero      (zero),
        .input_negative  (neg),
        .input_mem_ready (rdy),
        .output_ALUSrcA  (src_a),
        .output_ALUSrcB  (src_b),
        .output_ALUOp    (alu_op),
        .output_PCSrc    (pc_src),
        .output_PCWrite  (pc_write),
        .output_IRWrite  (ir_write),
        .output_IorD     (iord),
        .output_MemRead  (mem_read),
        .output_MemWrite (mem_write),
        .output_RegWrite (reg_write),
        .output_MemtoReg (mem_to_reg),
        .output_RegDst   (reg_dst),
        .output_state    (state),
        .output_illegal  (illegal)
    );

    // Observed word: {state, SrcA, SrcB, ALUOp, PCSrc, PCWrite, IRWrite, IorD,
    //                 MemRead, MemWrite, RegWrite, MemtoReg, RegDst, illegal}
    logic [20:0] act;
    assign act = {state, src_a, src_b, alu_op, pc_src, pc_write, ir_write, iord,
                  mem_read, mem_write, reg_write, mem_to_reg, reg_dst, illegal};

    // flags order: PCSrc PCWrite IRWrite IorD MemRead MemWrite RegWrite MemtoReg RegDst illegal
    function automatic logic [20:0] e(input logic [3:0] st, input logic [1:0] a,
                                      input logic [1:0] b, input logic [2:0] op,
                                      input logic [9:0] f);
        return {st, a, b, op, f};
    endfunction

    // Hand-derived per-cycle expectations
    logic [20:0] E_RST, E_FETCH_GO, E_FETCH_WAIT, E_DECODE, E_RWB, E_EXEC_I, E_IWB;
    logic [20:0] E_MEMADDR, E_MEMREAD, E_MEMWB, E_MEMWRITE, E_BR_T, E_BR_N, E_JUMP, E_TRAP;
    initial begin
        E_RST        = e(4'd0,  2'd0, 2'd0, 3'b000, 10'b0000000000);
        E_FETCH_GO   = e(4'd0,  2'd0, 2'd1, 3'b000, 10'b0110100000);
        E_FETCH_WAIT = e(4'd0,  2'd0, 2'd1, 3'b000, 10'b0000100000);
        E_DECODE     = e(4'd1,  2'd0, 2'd2, 3'b000, 10'b0000000000);
        E_RWB        = e(4'd7,  2'd0, 2'd0, 3'b000, 10'b0000001010);
        E_EXEC_I     = e(4'd8,  2'd2, 2'd2, 3'b000, 10'b0000000000);
        E_IWB        = e(4'd9,  2'd0, 2'd0, 3'b000, 10'b0000001000);
        E_MEMADDR    = e(4'd2,  2'd2, 2'd2, 3'b000, 10'b0000000000);
        E_MEMREAD    = e(4'd3,  2'd0, 2'd0, 3'b000, 10'b0001100000);
        E_MEMWB      = e(4'd4,  2'd0, 2'd0, 3'b000, 10'b0000001100);
        E_MEMWRITE   = e(4'd5,  2'd0, 2'd0, 3'b000, 10'b0001010000);
        E_BR_T       = e(4'd10, 2'd2, 2'd0, 3'b001, 10'b1100000000);
        E_BR_N       = e(4'd10, 2'd2, 2'd0, 3'b001, 10'b1000000000);
        E_JUMP       = e(4'd11, 2'd0, 2'd0, 3'b000, 10'b1100000000);
        E_TRAP       = e(4'd12, 2'd0, 2'd0, 3'b000, 10'b0000000001);
    end

    function automatic logic [20:0] exec_r(input logic [2:0] op);
        return e(4'd6, 2'd2, 2'd0, op, 10'b0000000000);
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue its expectation
    task automatic cyc(input logic r, input logic [3:0] opc, input logic z, input logic n,
                       input logic rd, input logic [20:0] exp_word, input string name);
        @(posedge clk);
        #1;
        rst_n  = r;
        opcode = opc;
        zero   = z;
        neg    = n;
        rdy    = rd;
        sb_q.push_back('{word: exp_word, name: name});
    endtask

    // Monitor: compare whatever the DUT presents mid-cycle against the queue head
    initial begin
        exp_t cur;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                cur = sb_q.pop_front();
                checks++;
                if (act !== cur.word) begin
                    failures++;
                    $display("FAIL %s: got %b required %b", cur.name, act, cur.word);
                end
            end
        end
    end

    initial begin
        // Reset held with mem_ready high
        cyc(0, 4'h0, 0, 0, 1, E_RST, "reset_a");
        cyc(0, 4'h0, 0, 0, 1, E_RST, "reset_b");

        // SUB; IR changes after DECODE must not affect ALUOp
        cyc(1, 4'h1, 0, 0, 1, E_FETCH_GO, "sub_fetch");
        cyc(1, 4'h1, 0, 0, 0, E_DECODE,   "sub_decode");
        cyc(1, 4'h0, 0, 0, 0, exec_r(3'b001), "sub_exec");
        cyc(1, 4'h0, 0, 0, 1, E_RWB,      "sub_rwb");

        // ADD / AND / OR with a fetch stall on the first
        cyc(1, 4'h0, 0, 0, 0, E_FETCH_WAIT, "add_fetch_wait");
        cyc(1, 4'h0, 0, 0, 1, E_FETCH_GO,   "add_fetch");
        cyc(1, 4'h0, 0, 0, 1, E_DECODE,     "add_decode");
        cyc(1, 4'h3, 0, 0, 1, exec_r(3'b000), "add_exec");
        cyc(1, 4'h3, 0, 0, 1, E_RWB,        "add_rwb");
        cyc(1, 4'h2, 0, 0, 1, E_FETCH_GO,   "and_fetch");
        cyc(1, 4'h2, 0, 0, 1, E_DECODE,     "and_decode");
        cyc(1, 4'h2, 0, 0, 1, exec_r(3'b010), "and_exec");
        cyc(1, 4'h2, 0, 0, 1, E_RWB,        "and_rwb");
        cyc(1, 4'h3, 0, 0, 1, E_FETCH_GO,   "or_fetch");
        cyc(1, 4'h3, 0, 0, 1, E_DECODE,     "or_decode");
        cyc(1, 4'h3, 0, 0, 1, exec_r(3'b011), "or_exec");
        cyc(1, 4'h3, 0, 0, 1, E_RWB,        "or_rwb");

        // ADDI
        cyc(1, 4'h4, 0, 0, 1, E_FETCH_GO, "addi_fetch");
        cyc(1, 4'h4, 0, 0, 1, E_DECODE,   "addi_decode");
        cyc(1, 4'h4, 0, 0, 1, E_EXEC_I,   "addi_exec");
        cyc(1, 4'h4, 0, 0, 1, E_IWB,      "addi_wb");

        // LW with three wait cycles; IR flips to SW after DECODE
        cyc(1, 4'h5, 0, 0, 1, E_FETCH_GO, "lw_fetch");
        cyc(1, 4'h5, 0, 0, 1, E_DECODE,   "lw_decode");
        cyc(1, 4'h6, 0, 0, 1, E_MEMADDR,  "lw_memaddr");
        cyc(1, 4'h6, 0, 0, 0, E_MEMREAD,  "lw_memread_w1");
        cyc(1, 4'h6, 0, 0, 0, E_MEMREAD,  "lw_memread_w2");
        cyc(1, 4'h6, 0, 0, 0, E_MEMREAD,  "lw_memread_w3");
        cyc(1, 4'h6, 0, 0, 1, E_MEMREAD,  "lw_memread_go");
        cyc(1, 4'h6, 0, 0, 1, E_MEMWB,    "lw_memwb");

        // SW, no wait
        cyc(1, 4'h6, 0, 0, 1, E_FETCH_GO, "sw_fetch");
        cyc(1, 4'h6, 0, 0, 1, E_DECODE,   "sw_decode");
        cyc(1, 4'h6, 0, 0, 1, E_MEMADDR,  "sw_memaddr");
        cyc(1, 4'h6, 0, 0, 1, E_MEMWRITE, "sw_memwrite");

        // Branches: BEQ taken/not, BNE taken, BLT taken/not (Zero must not matter)
        cyc(1, 4'h7, 1, 0, 1, E_FETCH_GO, "beq1_fetch");
        cyc(1, 4'h7, 1, 0, 1, E_DECODE,   "beq1_decode");
        cyc(1, 4'h7, 1, 0, 1, E_BR_T,     "beq_taken");
        cyc(1, 4'h7, 0, 0, 1, E_FETCH_GO, "beq0_fetch");
        cyc(1, 4'h7, 0, 0, 1, E_DECODE,   "beq0_decode");
        cyc(1, 4'h7, 0, 0, 1, E_BR_N,     "beq_not_taken");
        cyc(1, 4'h8, 0, 0, 1, E_FETCH_GO, "bne_fetch");
        cyc(1, 4'h8, 0, 0, 1, E_DECODE,   "bne_decode");
        cyc(1, 4'h8, 0, 0, 1, E_BR_T,     "bne_taken");
        cyc(1, 4'h9, 0, 1, 1, E_FETCH_GO, "blt1_fetch");
        cyc(1, 4'h9, 0, 1, 1, E_DECODE,   "blt1_decode");
        cyc(1, 4'h9, 0, 1, 1, E_BR_T,     "blt_taken");
        cyc(1, 4'h9, 1, 0, 1, E_FETCH_GO, "blt0_fetch");
        cyc(1, 4'h9, 1, 0, 1, E_DECODE,   "blt0_decode");
        cyc(1, 4'h9, 1, 0, 1, E_BR_N,     "blt_not_taken");

        // JMP
        cyc(1, 4'hA, 0, 0, 1, E_FETCH_GO, "jmp_fetch");
        cyc(1, 4'hA, 0, 0, 1, E_DECODE,   "jmp_decode");
        cyc(1, 4'hA, 0, 0, 1, E_JUMP,     "jmp_jump");

        // SW stalled, reset pulsed mid-stall aborts the write
        cyc(1, 4'h6, 0, 0, 1, E_FETCH_GO, "swr_fetch");
        cyc(1, 4'h6, 0, 0, 1, E_DECODE,   "swr_decode");
        cyc(1, 4'h6, 0, 0, 0, E_MEMADDR,  "swr_memaddr");
        cyc(1, 4'h6, 0, 0, 0, E_MEMWRITE, "swr_stall1");
        cyc(1, 4'h6, 0, 0, 0, E_MEMWRITE, "swr_stall2");
        cyc(0, 4'h6, 0, 0, 0, E_RST,      "swr_reset");
        cyc(1, 4'h6, 0, 0, 1, E_FETCH_GO, "swr_refetch");
        cyc(1, 4'hF, 0, 0, 1, E_DECODE,   "opf_decode");

        // Undefined opcode F
`ifdef ILLEGAL_TRAP_EN
        cyc(1, 4'h0, 0, 0, 1, E_TRAP,     "opf_trap1");
        cyc(1, 4'h0, 0, 0, 1, E_TRAP,     "opf_trap2");
        cyc(1, 4'h0, 0, 0, 1, E_TRAP,     "opf_trap3");
        cyc(0, 4'h0, 0, 0, 1, E_RST,      "opf_reset");
        cyc(1, 4'h0, 0, 0, 1, E_FETCH_GO, "opf_refetch");
`else
        cyc(1, 4'h0, 0, 0, 1, E_FETCH_GO, "opf_nop_fetch");
        cyc(1, 4'h0, 0, 0, 1, E_DECODE,   "opf_nop_decode");
`endif

        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
